fifo_rd_packer: RTL



---
 rtl/fifo_rd_packer_if.sv | 39 +++
 rtl/fifo_rd_packer.sv | 111 +++++++++++
 2 files changed

// File: rtl/fifo_rd_packer_if.sv
// Handshake bundle between the read-side FIFO, the packer and the downstream stage.
// The flush/out_fill pair exists only when PACKER_FLUSH_EN is defined.
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 3,
    parameter int PACK_COUNT = 4
);
`ifdef PACKER_FLUSH_EN
    localparam int CNT_W = $clog2(PACK_COUNT + 1);
`endif

    logic                             fifo_empty;
    logic [DATA_WIDTH-1:0]            fifo_rd_data;
    logic                             fifo_r_en;
    logic [DATA_WIDTH*PACK_COUNT-1:0] out_data;
    logic                             out_valid;
    logic                             out_ready;
`ifdef PACKER_FLUSH_EN
    logic                             flush;
    logic [CNT_W-1:0]                 out_fill;

    modport master (
        input  fifo_empty, fifo_rd_data, out_ready, flush,
        output fifo_r_en, out_data, out_valid, out_fill
    );
    modport slave (
        output fifo_empty, fifo_rd_data, out_ready, flush,
        input  fifo_r_en, out_data, out_valid, out_fill
    );
`else
    modport master (
        input  fifo_empty, fifo_rd_data, out_ready,
        output fifo_r_en, out_data, out_valid
    );
    modport slave (
        output fifo_empty, fifo_rd_data, out_ready,
        input  fifo_r_en, out_data, out_valid
    );
`endif
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops PACK_COUNT narrow FIFO entries (read latency 1) and presents them as one wide word.
// Optional partial-word flush is enabled with PACKER_FLUSH_EN.
//
// state    | meaning
// S_FILL   | issuing FIFO pops until PACK_COUNT are issued (or a flush)
// S_DRAIN  | no new pops; waiting for the in-flight read to land
// S_OUT    | word held on out_data with out_valid until out_ready
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 3,
    parameter int PACK_COUNT = 4,
    parameter int CNT_W      = $clog2(PACK_COUNT + 1)
) (
    input  logic                r_clk,
    input  logic                r_rst,
    fifo_rd_packer_if.master    bus,
    output logic                busy
);
    localparam int              OUT_W    = DATA_WIDTH * PACK_COUNT;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_COUNT);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_DRAIN = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   captured_q, captured_d;
    logic [OUT_W-1:0]   slots_q, slots_d;
    logic               rd_pend_q;
    logic               fifo_r_en;
    logic               flush_go;
    logic               out_valid;

    // A flush only matters once something has been popped for the current word.
`ifdef PACKER_FLUSH_EN
    assign flush_go = bus.flush && (state_q == S_FILL) &&
                      ((captured_q != '0) || rd_pend_q);
`else
    assign flush_go = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        captured_d = captured_q;
        slots_d    = slots_q;
        fifo_r_en  = 1'b0;

        if ((state_q == S_FILL) && !bus.fifo_empty && (issued_q < FULL_CNT) &&
            !r_rst && !flush_go) begin
            fifo_r_en = 1'b1;
        end
        if (fifo_r_en) begin
            issued_d = issued_q + 1'b1;
        end
        if (rd_pend_q && (captured_q < FULL_CNT)) begin
            slots_d[int'(captured_q)*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_rd_data;
            captured_d = captured_q + 1'b1;
        end

        case (state_q)
            S_FILL: begin
                if (flush_go || (issued_d == FULL_CNT)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Every issued read has landed once captured catches up with issued.
                if (captured_d == issued_q) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d    = S_FILL;
                    issued_d   = '0;
                    captured_d = '0;
                    slots_d    = '0;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state_q    <= S_FILL;
            issued_q   <= '0;
            captured_q <= '0;
            slots_q    <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            captured_q <= captured_d;
            slots_q    <= slots_d;
            rd_pend_q  <= fifo_r_en;
        end
    end

    assign out_valid     = (state_q == S_OUT);
    assign bus.fifo_r_en = fifo_r_en;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = slots_q;
`ifdef PACKER_FLUSH_EN
    assign bus.out_fill  = out_valid ? captured_q : '0;
`endif
    assign busy = (issued_q != '0) || rd_pend_q || out_valid;
endmodule
